// File: rtl/rr_stream_arbiter_if.sv
// rr_stream_arbiter_if: requester-side and downstream valid-ready bundle of the round-robin stream arbiter
interface rr_stream_arbiter_if #(parameter int NUM_REQ = 4, parameter int DATA_W = 64);
  localparam int IDX_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req_vld;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0] req_rdy;
  logic out_vld;
  logic out_last;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0] out_src;
  logic out_rdy;
  logic busy;
  modport slave (input req_vld, req_last, req_data, out_rdy,
                 output req_rdy, out_vld, out_last, out_data, out_src, busy);
  modport master (output req_vld, req_last, req_data, out_rdy,
                  input req_rdy, out_vld, out_last, out_data, out_src, busy);
endinterface

// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: packet-locked round-robin merge of NUM_REQ streams into one registered output
module rr_stream_arbiter #(parameter int NUM_REQ = 4, parameter int DATA_W = 64) (
  input logic clk,
  input logic rst,
  rr_stream_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n, owner, owner_n, w, sel, nxt, j;
  logic [NUM_REQ-1:0] rdy;
  logic any, load_en, take;
  assign load_en = !bus.out_vld || bus.out_rdy;
  // descending scan so the requester closest to ptr is written last and wins
  always_comb begin
    w = '0;
    any = 1'b0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (bus.req_vld[j]) begin
        w = j;
        any = 1'b1;
      end
    end
  end
  assign sel = (state == LOCK) ? owner : w;
  assign nxt = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    owner_n = owner;
    rdy = '0;
    rdy[sel] = (state == LOCK) ? load_en : load_en && any;
    take = |(rdy & bus.req_vld);
    if (take && bus.req_last[sel]) begin
      state_n = IDLE;
      ptr_n = nxt;
    end else if (take) begin
      state_n = LOCK;
      owner_n = sel;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      owner <= owner_n;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.out_vld <= 1'b0;
      bus.out_last <= 1'b0;
      bus.out_data <= '0;
      bus.out_src <= '0;
    end else if (take) begin
      bus.out_vld <= 1'b1;
      bus.out_last <= bus.req_last[sel];
      bus.out_data <= bus.req_data[sel*DATA_W +: DATA_W];
      bus.out_src <= sel;
    end else if (bus.out_rdy) begin
      bus.out_vld <= 1'b0;
    end
  // state is already IDLE under reset, but grants must be masked combinationally
  assign bus.req_rdy = rst ? '0 : rdy;
  assign bus.busy = !rst && (state == LOCK || bus.out_vld);
endmodule

// File: tb/tb_rr_stream_arbiter.sv
// tb_rr_stream_arbiter: directed-vector check of grant order, packet lock, stall and reset behaviour
module tb_rr_stream_arbiter;
  logic clk, rst;
  int vectors = 0;
  int miscompares = 0;
  rr_stream_arbiter_if #(.NUM_REQ(4), .DATA_W(64)) bus ();
  rr_stream_arbiter #(.NUM_REQ(4), .DATA_W(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int i, input logic v, input logic l, input logic [63:0] d);
    bus.req_vld[i] = v;
    bus.req_last[i] = l;
    bus.req_data[i*64 +: 64] = d;
  endtask
  task automatic do_reset;
    bus.req_vld = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    rst = 1;
    tick;
    rst = 0;
  endtask
  initial begin
    bus.out_rdy = 1;
    do_reset;
    chk("rst_vld", bus.out_vld, 0);
    chk("rst_src", bus.out_src, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_busy", bus.busy, 0);
    // all requesters streaming single-beat packets
    for (int i = 0; i < 4; i++) drive(i, 1, 1, 64'hA0 + i);
    #1;
    chk("t2_first_vld", bus.out_vld, 0);
    for (int k = 0; k < 6; k++) begin
      chk("t2_rdy", bus.req_rdy, 4'b1 << (k % 4));
      tick;
      chk("t2_vld", bus.out_vld, 1);
      chk("t2_src", bus.out_src, k % 4);
      chk("t2_data", bus.out_data, 64'hA0 + k % 4);
      #1;
    end
    // asynchronous reset mid-cycle with out_vld=1
    rst = 1;
    #1;
    chk("t1_vld", bus.out_vld, 0);
    chk("t1_src", bus.out_src, 0);
    chk("t1_rdy", bus.req_rdy, 0);
    chk("t1_busy", bus.busy, 0);
    tick;
    rst = 0;
    do_reset;
    // bring ptr to 1, then a 3-beat packet from req1 with req0/req2 contending
    drive(0, 1, 1, 64'h55);
    tick;
    drive(0, 1, 1, 64'hC0);
    drive(2, 1, 1, 64'hC2);
    drive(1, 1, 0, 64'hB0);
    #1;
    chk("t3_rdy_a", bus.req_rdy, 4'b0010);
    tick;
    chk("t3_src_a", bus.out_src, 1);
    chk("t3_data_a", bus.out_data, 64'hB0);
    drive(1, 1, 0, 64'hB1);
    #1;
    chk("t3_rdy_b", bus.req_rdy, 4'b0010);
    chk("t3_busy", bus.busy, 1);
    tick;
    chk("t3_data_b", bus.out_data, 64'hB1);
    chk("t3_last_b", bus.out_last, 0);
    drive(1, 1, 1, 64'hB2);
    #1;
    chk("t3_rdy_c", bus.req_rdy, 4'b0010);
    tick;
    chk("t3_data_c", bus.out_data, 64'hB2);
    chk("t3_last_c", bus.out_last, 1);
    drive(1, 0, 0, 64'h0);
    #1;
    chk("t3_rdy_d", bus.req_rdy, 4'b0100);
    tick;
    chk("t3_src_d", bus.out_src, 2);
    chk("t3_data_d", bus.out_data, 64'hC2);
    drive(2, 0, 0, 64'h0);
    #1;
    chk("t3_rdy_e", bus.req_rdy, 4'b0001);
    tick;
    chk("t3_src_e", bus.out_src, 0);
    chk("t3_data_e", bus.out_data, 64'hC0);
    drive(0, 0, 0, 64'h0);
    // downstream stall with ptr=1
    drive(1, 1, 1, 64'hE1);
    drive(3, 1, 1, 64'hE3);
    #1;
    chk("t4_rdy_a", bus.req_rdy, 4'b0010);
    tick;
    chk("t4_data_a", bus.out_data, 64'hE1);
    bus.out_rdy = 0;
    drive(1, 1, 1, 64'hE5);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_stall_rdy", bus.req_rdy, 0);
      tick;
      chk("t4_stall_vld", bus.out_vld, 1);
      chk("t4_stall_data", bus.out_data, 64'hE1);
    end
    bus.out_rdy = 1;
    #1;
    chk("t4_rdy_b", bus.req_rdy, 4'b1000);
    tick;
    chk("t4_src_b", bus.out_src, 3);
    chk("t4_data_b", bus.out_data, 64'hE3);
    drive(3, 0, 0, 64'h0);
    #1;
    chk("t4_rdy_c", bus.req_rdy, 4'b0010);
    tick;
    chk("t4_src_c", bus.out_src, 1);
    chk("t4_data_c", bus.out_data, 64'hE5);
    drive(1, 0, 0, 64'h0);
    tick;
    chk("t4_drained", bus.out_vld, 0);
    chk("t4_idle_busy", bus.busy, 0);
    // reset while req2 is mid-packet
    do_reset;
    drive(2, 1, 0, 64'hF0);
    #1;
    chk("t5_rdy_a", bus.req_rdy, 4'b0100);
    tick;
    drive(2, 1, 0, 64'hF1);
    tick;
    chk("t5_data_b", bus.out_data, 64'hF1);
    chk("t5_busy", bus.busy, 1);
    drive(2, 1, 0, 64'hF2);
    drive(0, 1, 1, 64'h70);
    #2;
    rst = 1;
    #1;
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_rdy", bus.req_rdy, 0);
    tick;
    chk("t5_rst_busy2", bus.busy, 0);
    chk("t5_rst_rdy2", bus.req_rdy, 0);
    rst = 0;
    #1;
    chk("t5_rdy_post", bus.req_rdy, 4'b0001);
    tick;
    chk("t5_src_post", bus.out_src, 0);
    chk("t5_data_post", bus.out_data, 64'h70);
    drive(0, 0, 0, 64'h0);
    drive(2, 0, 0, 64'h0);
    tick;
    // pointer wrap from 3 to 0
    do_reset;
    drive(2, 1, 1, 64'h82);
    tick;
    drive(2, 0, 0, 64'h0);
    drive(3, 1, 1, 64'h93);
    #1;
    chk("t6_rdy_a", bus.req_rdy, 4'b1000);
    tick;
    chk("t6_src_a", bus.out_src, 3);
    drive(3, 1, 1, 64'h94);
    #1;
    chk("t6_rdy_b", bus.req_rdy, 4'b1000);
    tick;
    chk("t6_data_b", bus.out_data, 64'h94);
    drive(3, 1, 1, 64'h95);
    drive(0, 1, 1, 64'h90);
    #1;
    chk("t6_rdy_c", bus.req_rdy, 4'b0001);
    tick;
    chk("t6_src_c", bus.out_src, 0);
    chk("t6_data_c", bus.out_data, 64'h90);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
